wb_master_arbiter: RTL and testbench
====================================

Name: wb_master_arbiter

Overview:
- Shares the single Wishbone slave-side bus, which feeds the address-decoding interconnect, between NM bus masters (CPU, DMA, debug/housekeeping).
- Round-robin arbitration; a grant is held for a master's whole cycle (cyc high).
- A bus watchdog terminates any strobe that no slave acknowledges (unmapped address) with an error pulse to the owning master.

Parameters:
- NM, 3, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TO_CYCLES, 255, cycles of strobe without ack before watchdog error (1..65535).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- wbm_cyc_i  input  NM  per-master cycle.
- wbm_stb_i  input  NM  per-master strobe.
- wbm_we_i  input  NM  per-master write enable.
- wbm_adr_i  input  NM*AW  per-master address; master k occupies bits [(k+1)*AW-1:k*AW].
- wbm_dat_i  input  NM*DW  per-master write data, packed the same way.
- wbm_sel_i  input  NM*(DW/8)  per-master byte selects, packed the same way.
- wbm_dat_o  output  DW  read data, broadcast to all masters.
- wbm_ack_o  output  NM  per-master ack.
- wbm_err_o  output  NM  per-master watchdog error.
- wbs_cyc_o  output  1  slave-side cycle.
- wbs_stb_o  output  1  slave-side strobe.
- wbs_we_o  output  1  slave-side write enable.
- wbs_adr_o  output  AW  slave-side address.
- wbs_dat_o  output  DW  slave-side write data.
- wbs_sel_o  output  DW/8  slave-side byte selects.
- wbs_dat_i  input  DW  read data from the interconnect.
- wbs_ack_i  input  1  ack from the interconnect.
- grant_o  output  NM  one-hot current owner (debug/status).

Behaviour:
- Reset (resetn low, asynchronous):
  - State IDLE; grant_o = 0; rr_ptr = NM-1, so master 0 wins first; watchdog count = 0.
  - All wbs_* outputs, wbm_ack_o and wbm_err_o are 0; wbm_dat_o = 0.
- IDLE:
  - Request k = wbm_cyc_i[k] & wbm_stb_i[k].
  - If any request is present, pick the first requester searching from rr_ptr+1 upward, wrapping modulo NM.
  - Register grant one-hot and set rr_ptr = winner; go to OWNED.
  - Arbitration latency is exactly 1 cycle: wbs_stb_o can first be high the cycle after the request is seen.
- OWNED (g = granted index):
  - wbs_cyc_o = wbm_cyc_i[g].
  - wbs_stb_o = wbm_cyc_i[g] & wbm_stb_i[g] & ~err_pulse.
  - wbs_we/adr/dat/sel_o follow master g combinationally.
  - In IDLE, wbs_adr/dat/sel/we_o = 0.
- Ack routing:
  - wbm_ack_o[g] = wbs_ack_i & wbs_stb_o, same cycle, combinational.
  - Non-owners always see ack = 0 and err = 0.
  - wbm_dat_o = wbs_dat_i while OWNED, else 0.
- Grant release:
  - Grant is held while wbm_cyc_i[g] is high, including across multiple strobes (burst/lock); requests from other masters wait.
  - Cycle where wbm_cyc_i[g] is low: return to IDLE, grant_o = 0. No new grant in that same cycle, so there is one idle cycle between owners.
- Watchdog:
  - 16-bit count, cleared in IDLE, on any wbs_ack_i and when wbs_stb_o is low; increments each cycle wbs_stb_o is high without ack.
  - When count == TO_CYCLES-1 and no ack arrives, next cycle: wbm_err_o[g] = 1 for exactly one cycle, wbs_stb_o forced 0 that cycle, count cleared.
  - Ack and timeout in the same cycle: the ack wins; no err is raised.
  - The master keeps its grant after err and may retry or drop cyc.
- wbs_ack_i while IDLE, or while wbs_stb_o = 0: ignored, routed nowhere.
- Master dropping stb but keeping cyc: bus stays owned, slave stb = 0, watchdog cleared.
- resetn asserted mid-transfer: all outputs go to 0 immediately; the transfer is abandoned; after release, arbitration restarts with master 0 as first priority.
- NM = 1: degenerates to a registered pass-through plus watchdog; rr_ptr stays 0.

Test Plan:
- Single access: master 1 raises cyc/stb, read of 0x2100_0004; slave acks 2 cycles after wbs_stb_o with data 0xDEADBEEF -> grant_o = 3'b010 one cycle after request; wbm_ack_o = 3'b010 for 1 cycle; wbm_dat_o = 0xDEADBEEF; grant released the cycle after cyc drops.
- Fairness: all 3 masters request continuously, each doing 1 single-ack cycle then dropping cyc for 1 cycle -> grant order 0,1,2,0,1,2; no master is granted twice while another is waiting.
- Burst lock: master 0 holds cyc for 4 strobes/acks while master 2 requests -> master 2 is not granted until the cycle after master 0's cyc drops; exactly 4 acks reach master 0.
- Watchdog: TO_CYCLES = 8, master 2 strobes unmapped 0x3000_0000 with no ack -> wbm_err_o = 3'b100 for exactly 1 cycle after 8 strobe cycles; wbs_stb_o is 0 that cycle; with the strobe held, err repeats every 9 cycles.
- Ack/timeout race: ack arrives on the terminal count cycle -> wbm_ack_o pulses, wbm_err_o stays 0.
- Reset mid-cycle: assert resetn low while master 1 owns with stb high -> wbs_stb_o, grant_o and acks drop to 0 asynchronously; after release with masters 1 and 2 requesting, master 1 is granted first (pointer restarts at master 0, the first requester found searching from 0 upward).

Source files
------------

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter
// Purpose  : Round-robin Wishbone master arbiter with bus watchdog.
// Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter #(
  parameter int NM        = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NM-1:0]        wbm_cyc_i,
  input  logic [NM-1:0]        wbm_stb_i,
  input  logic [NM-1:0]        wbm_we_i,
  input  logic [NM*AW-1:0]     wbm_adr_i,
  input  logic [NM*DW-1:0]     wbm_dat_i,
  input  logic [NM*(DW/8)-1:0] wbm_sel_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [NM-1:0]        wbm_ack_o,
  output logic [NM-1:0]        wbm_err_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic                 wbs_we_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [DW/8-1:0]      wbs_sel_o,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  output logic [NM-1:0]        grant_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]    r_state;
  logic [NM-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic [15:0]   r_wd_cnt;
  logic          r_err_pulse;

  logic [NM-1:0] w_req;
  logic [NM-1:0] w_win_oh;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_owned;
  logic          w_cyc;
  logic          w_mstb;
  logic          w_stb;
  logic          w_we;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;
  logic [SW-1:0] w_sel;

  assign w_req = wbm_cyc_i & wbm_stb_i;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int i = 1; i <= NM; i++) begin
      w_idx = IW'((int'(r_rr_ptr) + i) % NM);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  for (genvar k = 0; k < NM; k++) begin : g_win_oh
    assign w_win_oh[k] = w_found && (w_win == IW'(k));
  end

  // r_grant is all-zero in IDLE, so the AND-OR mux yields zeros there.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    for (int k = 0; k < NM; k++) begin
      w_adr = w_adr | (wbm_adr_i[k*AW +: AW] & {AW{r_grant[k]}});
      w_dat = w_dat | (wbm_dat_i[k*DW +: DW] & {DW{r_grant[k]}});
      w_sel = w_sel | (wbm_sel_i[k*SW +: SW] & {SW{r_grant[k]}});
    end
  end

  assign w_owned = (r_state == ST_OWNED);
  assign w_cyc   = |(r_grant & wbm_cyc_i);
  assign w_mstb  = |(r_grant & wbm_stb_i);
  assign w_we    = |(r_grant & wbm_we_i);
  assign w_stb   = w_cyc & w_mstb & ~r_err_pulse;

  assign wbs_cyc_o = w_cyc;
  assign wbs_stb_o = w_stb;
  assign wbs_we_o  = w_we;
  assign wbs_adr_o = w_adr;
  assign wbs_dat_o = w_dat;
  assign wbs_sel_o = w_sel;
  assign grant_o   = r_grant;
  assign wbm_ack_o = r_grant & {NM{wbs_ack_i & w_stb}};
  assign wbm_err_o = r_grant & {NM{r_err_pulse}};
  assign wbm_dat_o = w_owned ? wbs_dat_i : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= IW'(NM - 1);
      r_wd_cnt    <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_OWNED: begin
          if (!w_cyc) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
          // An ack on the terminal cycle takes precedence over the timeout.
          if (w_stb && !wbs_ack_i) begin
            if (r_wd_cnt == 16'(TO_CYCLES - 1)) begin
              r_wd_cnt    <= '0;
              r_err_pulse <= 1'b1;
            end else begin
              r_wd_cnt    <= r_wd_cnt + 16'd1;
              r_err_pulse <= 1'b0;
            end
          end else begin
            r_wd_cnt    <= '0;
            r_err_pulse <= 1'b0;
          end
        end
        default: begin
          r_wd_cnt    <= '0;
          r_err_pulse <= 1'b0;
          if (w_found) begin
            r_state  <= ST_OWNED;
            r_grant  <= w_win_oh;
            r_rr_ptr <= w_win;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arbiter
// Purpose  : Self-checking bench for wb_master_arbiter against a bus-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_master_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    cyc = '0, stb = '0, we = '0;
  logic [NM*AW-1:0] adr = '0;
  logic [NM*DW-1:0] wdat = '0;
  logic [NM*SW-1:0] sel = '0;
  logic [DW-1:0]    sdat = '0;
  logic             sack = 1'b0;

  logic [DW-1:0] wbm_dat_o;
  logic [NM-1:0] wbm_ack_o, wbm_err_o, grant_o;
  logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [SW-1:0] wbs_sel_o;

  wb_master_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we),
    .wbm_adr_i(adr), .wbm_dat_i(wdat), .wbm_sel_i(sel),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .grant_o(grant_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus-level model: who owns the bus, who won last, and how many
  // consecutive strobe cycles have gone unanswered.
  int owner = -1;
  int last  = NM - 1;
  int wd    = 0;
  bit errnow = 1'b0;

  function automatic bit exp_stb();
    return owner >= 0 && cyc[owner] && stb[owner] && !errnow;
  endfunction

  task automatic model_reset();
    owner = -1; last = NM - 1; wd = 0; errnow = 1'b0;
  endtask

  task automatic model_step();
    bit s;
    s = exp_stb();
    if (!resetn) begin
      model_reset();
    end else if (owner < 0) begin
      wd = 0; errnow = 1'b0;
      for (int i = 1; i <= NM; i++) begin
        int j;
        j = (last + i) % NM;
        if (owner < 0 && cyc[j] && stb[j]) begin
          owner = j; last = j;
        end
      end
    end else begin
      if (s && !sack) begin
        wd++;
        errnow = (wd == TO);
        if (errnow) wd = 0;
      end else begin
        wd = 0; errnow = 1'b0;
      end
      if (!cyc[owner]) owner = -1;
    end
  endtask

  logic [NM-1:0] obs_grant, obs_ack, obs_err;
  logic          obs_stb;
  logic [DW-1:0] obs_datm;

  task automatic cycle_check();
    logic [NM-1:0] eg;
    bit s;
    @(negedge clk);
    eg = '0;
    if (owner >= 0) eg[owner] = 1'b1;
    s = exp_stb();
    check("grant", grant_o, eg);
    check("s_cyc", wbs_cyc_o, owner >= 0 && cyc[owner]);
    check("s_stb", wbs_stb_o, s);
    check("s_we", wbs_we_o, owner >= 0 && we[owner]);
    check("s_adr", wbs_adr_o, owner >= 0 ? adr[owner*AW +: AW] : '0);
    check("s_dat", wbs_dat_o, owner >= 0 ? wdat[owner*DW +: DW] : '0);
    check("s_sel", wbs_sel_o, owner >= 0 ? sel[owner*SW +: SW] : '0);
    check("m_ack", wbm_ack_o, (s && sack) ? eg : '0);
    check("m_err", wbm_err_o, errnow ? eg : '0);
    check("m_dat", wbm_dat_o, owner >= 0 ? sdat : '0);
    obs_grant = grant_o; obs_ack = wbm_ack_o; obs_err = wbm_err_o;
    obs_stb = wbs_stb_o; obs_datm = wbm_dat_o;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NM; k++) begin
      adr[k*AW +: AW] = $urandom;
      wdat[k*DW +: DW] = $urandom;
      sel[k*SW +: SW] = SW'($urandom);
    end
    we = NM'($urandom);
    sdat = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q[$];
    int nerr, badstb, nack, badgrant, ack_pct;
    logic [NM-1:0] prev_grant;

    rand_payload();
    cycle_check();
    cycle_check();
    resetn = 1'b1;

    // Fairness: everyone requests, each drops cyc for one cycle after its ack.
    cyc = '1; stb = '1; sack = 1'b1; prev_grant = '0;
    for (int n = 0; n < 30; n++) begin
      cycle_check();
      if (obs_grant != 0 && obs_grant != prev_grant)
        q.push_back($clog2(int'(obs_grant)));
      prev_grant = obs_grant;
      cyc = ~obs_ack; stb = cyc;
    end
    check("fair_cnt", q.size() >= 6, 1'b1);
    for (int n = 0; n < 6 && n < q.size(); n++)
      check("fair_order", q[n], n % 3);
    cyc = '0; stb = '0; sack = 1'b0;
    cycle_check(); cycle_check();

    // Single read by master 1.
    cyc = 3'b010; stb = 3'b010; we = '0; adr[1*AW +: AW] = 32'h2100_0004;
    cycle_check();
    cycle_check();
    check("single_grant", obs_grant, 3'b010);
    cycle_check();
    sack = 1'b1; sdat = 32'hDEAD_BEEF;
    cycle_check();
    check("single_ack", obs_ack, 3'b010);
    check("single_dat", obs_datm, 32'hDEAD_BEEF);
    cyc = '0; stb = '0; sack = 1'b0;
    cycle_check();
    cycle_check();
    check("single_release", obs_grant, 3'b000);

    // Burst lock: master 0 holds cyc for 4 acks while master 2 waits.
    cyc = 3'b001; stb = 3'b001;
    cycle_check();
    cyc = 3'b101; stb = 3'b101; nack = 0; badgrant = 0;
    for (int n = 0; n < 8; n++) begin
      sack = n[0];
      cycle_check();
      if (obs_ack[0]) nack++;
      if (obs_grant != 3'b001) badgrant++;
    end
    check("burst_acks", nack, 4);
    check("burst_lock", badgrant, 0);
    cyc = 3'b100; stb = 3'b100; sack = 1'b0;
    cycle_check();
    check("burst_hold", obs_grant, 3'b001);
    cycle_check();
    check("burst_gap", obs_grant, 3'b000);

    // Watchdog: master 2 strobes an unmapped address with no ack.
    adr[2*AW +: AW] = 32'h3000_0000;
    cycle_check();
    check("wd_grant", obs_grant, 3'b100);
    nerr = 0; badstb = 0;
    for (int n = 2; n <= 27; n++) begin
      cycle_check();
      if (obs_err == 3'b100) begin
        nerr++;
        if (obs_stb) badstb++;
        check("wd_period", n % 9, 0);
      end
    end
    check("wd_err_cnt", nerr, 3);
    check("wd_stb_low", badstb, 0);
    // Ack on the terminal-count cycle beats the timeout.
    for (int n = 0; n < 7; n++) cycle_check();
    sack = 1'b1;
    cycle_check();
    check("race_ack", obs_ack, 3'b100);
    sack = 1'b0;
    cycle_check();
    check("race_no_err", obs_err, 3'b000);
    cyc = '0; stb = '0;
    cycle_check(); cycle_check();

    // Randomized traffic with varying slave responsiveness.
    ack_pct = 50;
    for (int n = 0; n < 2000; n++) begin
      if (n % 200 == 0) ack_pct = (n / 200 % 3 == 0) ? 0 : ((n / 200 % 3 == 1) ? 30 : 70);
      rand_payload();
      for (int k = 0; k < NM; k++) begin
        if (cyc[k]) begin
          if ($urandom_range(15) == 0) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
          end else begin
            stb[k] = ($urandom_range(3) != 0);
          end
        end else if ($urandom_range(3) == 0) begin
          cyc[k] = 1'b1; stb[k] = 1'b1;
        end
      end
      sack = ($urandom_range(99) < ack_pct);
      cycle_check();
    end
    cyc = '0; stb = '0; sack = 1'b0;
    cycle_check(); cycle_check();

    // Asynchronous reset while master 1 owns the bus mid-strobe.
    cyc = 3'b010; stb = 3'b010;
    cycle_check();
    cycle_check();
    check("rst_pre_grant", obs_grant, 3'b010);
    #2;
    sack = 1'b1;
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_async_stb", wbs_stb_o, 1'b0);
    check("rst_async_grant", grant_o, 3'b000);
    check("rst_async_ack", wbm_ack_o, 3'b000);
    sack = 1'b0; cyc = 3'b110; stb = 3'b110;
    cycle_check();
    resetn = 1'b1;
    cycle_check();
    cycle_check();
    check("rst_first_grant", obs_grant, 3'b010);
    cyc = '0; stb = '0;
    cycle_check(); cycle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
